// File: rtl/q_perm_pipe.sv
// Multi-lane Twofish q0/q1 byte permutation, two register stages with valid/ready flow control.
// Stage 1 holds the t0/t1 nibbles; stage 2 produces the final permuted byte per lane.
module q_perm_pipe #(
   parameter int LANES = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   input  logic [LANES-1:0]     in_sel,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 busy,
   output logic [CNT_W-1:0]     beat_cnt
);

   // First index is the q selector: 0 = q0, 1 = q1.
   localparam logic [3:0] T0 [0:1][0:15] = '{
      '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2, 4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4},
      '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE, 4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5}};
   localparam logic [3:0] T1 [0:1][0:15] = '{
      '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5, 4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD},
      '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7, 4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8}};
   localparam logic [3:0] T2 [0:1][0:15] = '{
      '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0, 4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1},
      '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA, 4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF}};
   localparam logic [3:0] T3 [0:1][0:15] = '{
      '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE, 4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA},
      '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE, 4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA}};

   // b' = a ^ ROR4(b,1) ^ ((a<<3) mod 16)
   function automatic logic [3:0] mix_b(input logic [3:0] a, input logic [3:0] b);
      return a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
   endfunction

   logic                 s1_valid;
   logic                 s2_valid;
   logic                 s1_load;
   logic                 s2_load;
   logic [8*LANES-1:0]   s1_data;
   logic [LANES-1:0]     s1_sel;
   logic [TAG_W-1:0]     s1_tag;
   logic [8*LANES-1:0]   s1_next;
   logic [8*LANES-1:0]   s2_next;

   assign s2_load   = s1_valid && (!s2_valid || out_ready);
   assign in_ready  = !s1_valid || s2_load;
   assign s1_load   = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign busy      = s1_valid | s2_valid;

   // NOTE: give every always_comb output a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      s1_next = '0;
      s2_next = '0;
      for (int i = 0; i < LANES; i++) begin
         s1_next[8*i+4 +: 4] = T0[in_sel[i]][in_data[8*i+4 +: 4] ^ in_data[8*i +: 4]];
         s1_next[8*i   +: 4] = T1[in_sel[i]][mix_b(in_data[8*i+4 +: 4], in_data[8*i +: 4])];
         s2_next[8*i+4 +: 4] = T3[s1_sel[i]][mix_b(s1_data[8*i+4 +: 4], s1_data[8*i +: 4])];
         s2_next[8*i   +: 4] = T2[s1_sel[i]][s1_data[8*i+4 +: 4] ^ s1_data[8*i +: 4]];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         out_data <= '0;
         out_tag  <= '0;
         beat_cnt <= '0;
      end else begin
         // Whenever stage 1 can take a beat it is either empty or draining into stage 2.
         if (in_ready)
            s1_valid <= in_valid;
         if (s2_load)
            s2_valid <= 1'b1;
         else if (out_ready)
            s2_valid <= 1'b0;
         if (s2_load) begin
            out_data <= s2_next;
            out_tag  <= s1_tag;
         end
         if (s2_valid && out_ready)
            beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   // NOTE: stage-1 payload is qualified by s1_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_data <= s1_next;
         s1_sel  <= in_sel;
         s1_tag  <= in_tag;
      end
   end

endmodule

// File: tb/tb_q_perm_pipe.sv
// Self-checking bench for q_perm_pipe: byte-table reference model, scoreboard and directed/random traffic.
module tb_q_perm_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [3:0]  in_sel = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
   logic        busy;
   logic [15:0] beat_cnt;

   // Second instance with a narrow counter to observe wrap-around.
   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [31:0] in_data2 = '0;
   logic        out_valid2;
   logic [31:0] out_data2;
   logic [3:0]  out_tag2;
   logic        busy2;
   logic [3:0]  beat_cnt2;

   always #5 clk = ~clk;

   q_perm_pipe #(.LANES(4), .TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .busy(busy), .beat_cnt(beat_cnt));

   q_perm_pipe #(.LANES(4), .TAG_W(4), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_sel(4'b1010), .in_tag(4'h3),
      .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_tag(out_tag2),
      .busy(busy2), .beat_cnt(beat_cnt2));

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: full 256-entry byte tables for q0/q1, built from the nibble rules.
   logic [63:0] tabs [2][4];
   logic [7:0]  q_tab [2][256];

   function automatic int nib(input logic [63:0] t, input int i);
      return int'((t >> (60 - 4*i)) & 64'hF);
   endfunction

   task automatic build_tables();
      int a, b, a1, b1, a2, b2, a3, b3;
      tabs[0][0] = 64'h817D_6F32_0B59_ECA4;  tabs[1][0] = 64'h28BD_F76E_3194_0AC5;
      tabs[0][1] = 64'hECB8_1235_F4A6_709D;  tabs[1][1] = 64'h1E2B_4C37_6DA5_F908;
      tabs[0][2] = 64'hBA5E_6D90_C8F3_2471;  tabs[1][2] = 64'h4C75_169A_0ED8_2B3F;
      tabs[0][3] = 64'hD7F4_126E_9B30_85CA;  tabs[1][3] = 64'hB951_C3DE_647F_208A;
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 256; x++) begin
            a  = x / 16;  b = x % 16;
            a1 = a ^ b;
            b1 = a ^ (((b >> 1) | (b << 3)) & 15) ^ ((a * 8) % 16);
            a2 = nib(tabs[s][0], a1);
            b2 = nib(tabs[s][1], b1);
            a3 = a2 ^ b2;
            b3 = a2 ^ (((b2 >> 1) | (b2 << 3)) & 15) ^ ((a2 * 8) % 16);
            q_tab[s][x] = 8'(nib(tabs[s][3], b3) * 16 + nib(tabs[s][2], a3));
         end
   endtask

   function automatic logic [31:0] ref_word(input logic [3:0] s, input logic [31:0] d);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = q_tab[s[i]][d[8*i +: 8]];
      return r;
   endfunction

   // Scoreboard of accepted-but-undelivered beats.
   typedef struct {
      logic [31:0] d;
      logic [3:0]  t;
   } beat_t;

   beat_t       sb [$];
   logic [15:0] exp_cnt = '0;
   logic        mon_en = 1'b0;
   logic        in_acc = 1'b0;
   logic        stall_prev = 1'b0;
   logic [35:0] held = '0;
   int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
   int          cyc = 0;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Handshakes decided here take effect at the next rising edge.
   always @(negedge clk) begin
      beat_t e;
      if (mon_en) begin
         check("busy", busy, sb.size() != 0);
         check("beat_cnt", beat_cnt, exp_cnt);
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {out_tag, out_data}, held);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0)
               fail_now("out beat with empty scoreboard");
            else begin
               e = sb.pop_front();
               check("out_data", out_data, e.d);
               check("out_tag", out_tag, e.t);
            end
            exp_cnt++;
         end
         stall_prev = out_valid && !out_ready;
         held       = {out_tag, out_data};
         if (in_valid && in_ready)
            sb.push_back('{d: ref_word(in_sel, in_data), t: in_tag});
         in_acc = in_valid && in_ready;
      end else begin
         in_acc     = 1'b0;
         stall_prev = 1'b0;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] s, input logic [3:0] t, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) cycle();
      in_valid = 1'b1;
      in_data  = d;
      in_sel   = s;
      in_tag   = t;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!in_acc && n < 200);
      if (!in_acc) fail_now("send timeout");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         cycle();
         n++;
      end
      if (sb.size() != 0) fail_now("drain timeout");
      cycle();
   endtask

   task automatic do_reset();
      mon_en   = 1'b0;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      cycle();
      sb.delete();
      exp_cnt = '0;
      cycle();
      rst_n = 1'b1;
      cycle();
      mon_en = 1'b1;
   endtask

   initial begin
      int n_acc;
      int start;
      int seen;
      logic [255:0] hit;

      build_tables();
      check("model_q0_00", q_tab[0][8'h00], 8'hA9);
      check("model_q0_01", q_tab[0][8'h01], 8'h67);
      check("model_q1_00", q_tab[1][8'h00], 8'h75);
      check("model_q1_01", q_tab[1][8'h01], 8'hF3);
      for (int s = 0; s < 2; s++) begin
         hit = '0;
         seen = 0;
         for (int x = 0; x < 256; x++) hit[q_tab[s][x]] = 1'b1;
         for (int x = 0; x < 256; x++) seen += int'(hit[x]);
         check(s == 0 ? "model_q0_bijective" : "model_q1_bijective", seen, 256);
      end

      rdy_mode = 0;
      cycle();
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_out_data", {out_tag, out_data}, 0);
      do_reset();

      // Directed single beats with literal results.
      send(32'h0000_0100, 4'b0000, 4'h1, 0);
      cycle();
      check("q0_literal_valid", out_valid, 1);
      check("q0_literal", out_data, 32'hA9A9_67A9);
      send(32'h0000_0100, 4'b1111, 4'h2, 0);
      cycle();
      check("q1_literal", out_data, 32'h7575_F375);
      drain();

      // Back-to-back stream of 16 tags, mixed selection.
      do_reset();
      start = cyc;
      for (int t = 0; t < 16; t++) send(32'h0, 4'b0101, 4'(t), 0);
      check("stream_cycles", cyc - start, 16);
      cycle();
      check("mixed_literal", out_data, 32'hA975_A975);
      drain();
      check("stream_beat_cnt", beat_cnt, 16);

      // Stall with pending stream: exactly two beats fit.
      rdy_mode = 2;
      cycle();
      cycle();
      in_valid = 1'b1;
      in_data  = $urandom;
      in_sel   = 4'($urandom);
      in_tag   = 4'h0;
      n_acc    = 0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         if (in_acc) begin
            n_acc++;
            in_tag  = 4'(n_acc);
            in_data = $urandom;
         end
      end
      check("accepted_while_stalled", n_acc, 2);
      check("in_ready_stalled", in_ready, 0);
      rdy_mode = 0;
      send(in_data, in_sel, in_tag, 0);
      send($urandom, 4'($urandom), 4'h3, 0);
      drain();

      // Random traffic with random backpressure.
      rdy_mode = 1;
      for (int k = 0; k < 300; k++)
         send($urandom, 4'($urandom), 4'($urandom), $urandom_range(0, 2));
      drain();

      // Every byte value in every lane under both selections.
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 256; k++)
            send({8'(k + 192), 8'(k + 128), 8'(k + 64), 8'(k)}, s == 0 ? 4'h0 : 4'hF, 4'(k), 0);
      drain();

      // Reset with both stages full.
      rdy_mode = 2;
      cycle();
      cycle();
      send(32'h1234_5678, 4'b0011, 4'h7, 0);
      send(32'h9ABC_DEF0, 4'b1100, 4'h8, 0);
      check("full_busy", busy, 1);
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, 0);
      mon_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_out_data", {out_tag, out_data}, 0);
      check("rst_in_ready", in_ready, 1);
      sb.delete();
      exp_cnt  = '0;
      rdy_mode = 0;
      cycle();
      rst_n = 1'b1;
      cycle();
      mon_en = 1'b1;
      send(32'h0000_0100, 4'b0000, 4'h5, 0);
      drain();

      // Narrow counter wraps: 17 deliveries read as 1.
      for (int k = 0; k < 17; k++) begin
         in_valid2 = 1'b1;
         in_data2  = $urandom;
         cycle();
         if (!in_ready2) fail_now("dut2 in_ready low");
      end
      in_valid2 = 1'b0;
      repeat (4) cycle();
      check("cnt_wrap", beat_cnt2, 4'h1);
      check("cnt_wrap_idle", busy2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

endmodule
